instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multicycle control sequencer for the LEGv8 single-issue datapath. It steps each instruction through fetch, decode, execute, memory and writeback.
- Issues instruction and data memory requests with a req/ack handshake, and generates IR load, register-file write and PC update strobes.
- Consumes the combinational control signals produced by the instruction decoder and the ALU zero flag.

Parameters:
- TIMEOUT_CYCLES, 255: consecutive req-without-ack cycles before the ERROR state; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must hold TIMEOUT_CYCLES.
- COUNT_WIDTH, 32: width of the retired-instruction counter (optional feature).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin execution from IDLE.
- halt  in  1  finish current instruction, then return to IDLE.
- imem_ack  in  1  instruction memory has returned data.
- dmem_ack  in  1  data memory access complete.
- Uncondbranch, Branch, MemRead, MemWrite, RegWrite  in  1 each  decoder control signals.
- cbnz  in  1  instruction bit 24 (1 = CBNZ, 0 = CBZ).
- alu_zero  in  1  ALU zero flag.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  capture fetched word into IR.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write qualifier, valid only while dmem_req is high.
- rf_we  out  1  register-file write strobe.
- pc_write  out  1  PC update strobe.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- busy  out  1  sequencer is not in IDLE or ERROR.
- error  out  1  memory handshake timeout occurred.
- retired_count  out  COUNT_WIDTH  retired instructions (optional feature).

Behaviour:
- Reset and interface:
  - Synchronous, active-low reset on rst_n, one clock, clk.
  - rst_n=0 at a rising edge forces IDLE and clears every output, pc_src, halt_pending, the wait counter and retired_count to 0. This applies from any state, including mid-handshake; outstanding requests are simply dropped.
  - All outputs are registered, Moore-decoded from the state.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, PCUPD, ERROR.
- Transitions:
  - IDLE: if start=1 and halt=0, go to FETCH. Otherwise stay. start=halt=1 in IDLE stays in IDLE.
  - FETCH: imem_req=1. If imem_ack=1, go to DECODE; otherwise stay and increment the wait counter.
  - DECODE: ir_load=1 for exactly 1 cycle. Always go to EXECUTE.
  - EXECUTE: 1 cycle. At its end, latch taken = Uncondbranch | (Branch & (alu_zero ^ cbnz)) into pc_src. Next state: MEM if MemRead|MemWrite, else WB if RegWrite, else PCUPD.
  - MEM: dmem_req=1, dmem_we=MemWrite. Stay until dmem_ack=1. Then go to WB if MemRead, else PCUPD.
  - WB: rf_we=1 for 1 cycle. Go to PCUPD.
  - PCUPD: pc_write=1 for 1 cycle with pc_src valid. Go to IDLE if halt_pending, else FETCH.
  - ERROR: all strobes 0, error=1, busy=0. Only reset exits.
- Handshake:
  - The req output stays high until ack is sampled high.
  - An ack on the first request cycle completes in that cycle.
  - An ack while no req is active is ignored.
  - The wait counter clears on entry to FETCH/MEM and on ack.
- Timeout: if req has been high for TIMEOUT_CYCLES consecutive cycles with no ack, the next state is ERROR. An ack arriving in cycle TIMEOUT_CYCLES is still accepted.
- Halt:
  - halt=1 in any busy cycle sets halt_pending.
  - halt_pending is cleared on entry to IDLE.
  - start is ignored while busy.
- Latency with zero-wait memory (FETCH entry to next FETCH entry):
  - branch/NOP: 4 cycles
  - store: 5 cycles
  - R/I-type: 5 cycles
  - load: 6 cycles
- Control-input sampling: control inputs are sampled only in EXECUTE. MemRead is sampled again at MEM exit. Control inputs are don't-care elsewhere.
- pc_src holds its latched value until the next EXECUTE.

Optional Feature:
- INSTR_COUNT_EN defined: retired_count increments by 1 on every PCUPD cycle and wraps to 0 at 2^COUNT_WIDTH.
- INSTR_COUNT_EN not defined: no counter logic; retired_count is tied to 0 and the port list is unchanged.

Test Plan:
- ADD with zero-wait memory: start=1, imem_ack=1 in the first FETCH cycle, RegWrite=1 -> imem_req high 1 cycle, then ir_load, then EXECUTE, then rf_we, then pc_write with pc_src=0. Next FETCH starts exactly 5 cycles after the first.
- LDUR, dmem_ack delayed 3 cycles: MemRead=1, RegWrite=1 -> dmem_req=1 and dmem_we=0 for 4 cycles, then rf_we, then pc_write. STUR with MemWrite=1 -> dmem_we=1 and no rf_we.
- CBNZ: Branch=1, cbnz=1, alu_zero=0 -> pc_src=1 at pc_write, no rf_we. Same stimulus with alu_zero=1 -> pc_src=0. Uncondbranch=1 -> pc_src=1 regardless of alu_zero.
- Timeout with TIMEOUT_CYCLES=4: imem_ack held 0 -> imem_req high for 4 cycles, then error=1, busy=0, all strobes 0 until rst_n=0. Ack in cycle 4 -> normal DECODE.
- halt pulsed in EXECUTE of a load -> the load completes (WB, PCUPD), then IDLE, busy=0, no further imem_req. rst_n=0 during MEM -> next cycle IDLE with all outputs 0.
- With INSTR_COUNT_EN: run 3 instructions -> retired_count=3. Preset near wrap with COUNT_WIDTH=2 and run 5 instructions -> retired_count=1.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction/data memory req/ack handshake bundle.
interface instr_sequencer_if;
    logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    modport master(output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
    modport slave(input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multicycle LEGv8 control sequencer (fetch/decode/execute/mem/wb/pc update).
// Defining INSTR_COUNT_EN adds the retired-instruction counter; otherwise retired_count is 0.
module instr_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W = 8,
    parameter int COUNT_WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic halt,
    input  logic Uncondbranch,
    input  logic Branch,
    input  logic MemRead,
    input  logic MemWrite,
    input  logic RegWrite,
    input  logic cbnz,
    input  logic alu_zero,
    instr_sequencer_if.master mem,
    output logic ir_load,
    output logic rf_we,
    output logic pc_write,
    output logic pc_src,
    output logic busy,
    output logic error,
    output logic [COUNT_WIDTH-1:0] retired_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WB, PCUPD, ERROR} state_t;
    state_t state, nxt;
    logic [CNT_W-1:0] cnt;
    logic halt_pending, req, ack, timeout;

    always_comb begin
        req = state == FETCH || state == MEM;
        ack = (state == FETCH && mem.imem_ack) || (state == MEM && mem.dmem_ack);
        // an ack in the last allowed cycle still wins over the timeout
        timeout = req && !ack && TIMEOUT_CYCLES != 0 && int'(cnt) + 1 == TIMEOUT_CYCLES;
        nxt = state;
        case (state)
            IDLE:    nxt = start && !halt ? FETCH : IDLE;
            FETCH:   nxt = ack ? DECODE : timeout ? ERROR : FETCH;
            DECODE:  nxt = EXECUTE;
            EXECUTE: nxt = MemRead || MemWrite ? MEM : RegWrite ? WB : PCUPD;
            MEM:     nxt = ack ? (MemRead ? WB : PCUPD) : timeout ? ERROR : MEM;
            WB:      nxt = PCUPD;
            PCUPD:   nxt = halt_pending ? IDLE : FETCH;
            default: nxt = ERROR;
        endcase
    end

    // outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            halt_pending <= 1'b0;
            pc_src <= 1'b0;
            mem.imem_req <= 1'b0;
            mem.dmem_req <= 1'b0;
            mem.dmem_we <= 1'b0;
            ir_load <= 1'b0;
            rf_we <= 1'b0;
            pc_write <= 1'b0;
            busy <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= req && !ack ? cnt + 1'b1 : '0;
            halt_pending <= nxt != IDLE && (halt_pending || (busy && halt));
            if (state == EXECUTE) pc_src <= Uncondbranch || (Branch && (alu_zero ^ cbnz));
            mem.imem_req <= nxt == FETCH;
            mem.dmem_req <= nxt == MEM;
            mem.dmem_we <= nxt == MEM && (state == EXECUTE ? MemWrite : mem.dmem_we);
            ir_load <= nxt == DECODE;
            rf_we <= nxt == WB;
            pc_write <= nxt == PCUPD;
            busy <= nxt != IDLE && nxt != ERROR;
            error <= nxt == ERROR;
        end
    end

`ifdef INSTR_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) retired_count <= '0;
        else if (state == PCUPD) retired_count <= retired_count + 1'b1;
    end
`else
    assign retired_count = '0;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed-vector bench for instr_sequencer (timeout shortened to 4 cycles).
module tb_instr_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, halt = 1'b0;
    logic Uncondbranch = 1'b0, Branch = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, RegWrite = 1'b0;
    logic cbnz = 1'b0, alu_zero = 1'b0;
    logic ir_load, rf_we, pc_write, pc_src, busy, error;
    logic ir_load2, rf_we2, pc_write2, pc_src2, busy2, error2;
    logic [31:0] retired_count;
    logic [1:0] rc2;
    logic [8:0] o;
    int errors = 0, checks = 0;
`ifdef INSTR_COUNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    instr_sequencer_if m();
    instr_sequencer_if m2();
    assign m2.imem_ack = m.imem_ack;
    assign m2.dmem_ack = m.dmem_ack;

    instr_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(8), .COUNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .Uncondbranch(Uncondbranch), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .cbnz(cbnz), .alu_zero(alu_zero), .mem(m),
        .ir_load(ir_load), .rf_we(rf_we), .pc_write(pc_write), .pc_src(pc_src),
        .busy(busy), .error(error), .retired_count(retired_count));

    instr_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(8), .COUNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .Uncondbranch(Uncondbranch), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .cbnz(cbnz), .alu_zero(alu_zero), .mem(m2),
        .ir_load(ir_load2), .rf_we(rf_we2), .pc_write(pc_write2), .pc_src(pc_src2),
        .busy(busy2), .error(error2), .retired_count(rc2));

    always #5 clk = ~clk;

    // {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_write, pc_src, busy, error}
    assign o = {m.imem_req, ir_load, m.dmem_req, m.dmem_we, rf_we, pc_write, pc_src, busy, error};

    task automatic do_reset();
        rst_n = 1'b0;
        {start, halt, m.imem_ack, m.dmem_ack} = 4'b0000;
        {Uncondbranch, Branch, MemRead, MemWrite, RegWrite, cbnz, alu_zero} = 7'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {start, halt, m.imem_ack, m.dmem_ack} = 4'b1011;
        repeat (2) @(negedge clk);
        checks++;
        if (o !== 9'b0) begin errors++; $display("FAIL reset_outputs: got %b want %b", o, 9'b0); end
        checks++;
        if (retired_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", retired_count); end
        do_reset();
    endtask

    task automatic test_add();
        logic [3:0] iv [6] = '{4'b1000, 4'b0010, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        logic [8:0] ev [6] = '{9'b100000010, 9'b010000010, 9'b000000010,
                               9'b000010010, 9'b000001010, 9'b100000010};
        do_reset();
        RegWrite = 1'b1;
        for (int i = 0; i < 6; i++) begin
            {start, halt, m.imem_ack, m.dmem_ack} = iv[i];
            @(negedge clk);
            checks++;
            if (o !== ev[i]) begin errors++; $display("FAIL add[%0d]: got %b want %b", i, o, ev[i]); end
        end
    endtask

    task automatic test_load();
        logic [3:0] iv [10] = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        logic [8:0] ev [10] = '{9'b100000010, 9'b010000010, 9'b000000010, 9'b001000010, 9'b001000010,
                                9'b001000010, 9'b001000010, 9'b000010010, 9'b000001010, 9'b100000010};
        do_reset();
        {MemRead, RegWrite} = 2'b11;
        for (int i = 0; i < 10; i++) begin
            {start, halt, m.imem_ack, m.dmem_ack} = iv[i];
            @(negedge clk);
            checks++;
            if (o !== ev[i]) begin errors++; $display("FAIL load[%0d]: got %b want %b", i, o, ev[i]); end
        end
    endtask

    task automatic test_store();
        logic [3:0] iv [6] = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        logic [8:0] ev [6] = '{9'b100000010, 9'b010000010, 9'b000000010,
                               9'b001100010, 9'b000001010, 9'b100000010};
        do_reset();
        MemWrite = 1'b1;
        for (int i = 0; i < 6; i++) begin
            {start, halt, m.imem_ack, m.dmem_ack} = iv[i];
            @(negedge clk);
            checks++;
            if (o !== ev[i]) begin errors++; $display("FAIL store[%0d]: got %b want %b", i, o, ev[i]); end
        end
    endtask

    task automatic test_branch();
        logic [3:0] iv [13] = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000,
                                4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        logic [8:0] ev [13] = '{9'b100000010, 9'b010000010, 9'b000000010, 9'b000001110, 9'b100000110,
                                9'b010000110, 9'b000000110, 9'b000001010, 9'b100000010,
                                9'b010000010, 9'b000000010, 9'b000001110, 9'b100000110};
        do_reset();
        {Branch, cbnz, alu_zero} = 3'b110;
        for (int i = 0; i < 13; i++) begin
            if (i == 5) alu_zero = 1'b1;
            if (i == 9) {Uncondbranch, Branch} = 2'b10;
            {start, halt, m.imem_ack, m.dmem_ack} = iv[i];
            @(negedge clk);
            checks++;
            if (o !== ev[i]) begin errors++; $display("FAIL branch[%0d]: got %b want %b", i, o, ev[i]); end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] iv [7] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0011};
        logic [8:0] ev [7] = '{9'b100000010, 9'b100000010, 9'b100000010, 9'b100000010,
                               9'b000000001, 9'b000000001, 9'b000000001};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            {start, halt, m.imem_ack, m.dmem_ack} = iv[i];
            @(negedge clk);
            checks++;
            if (o !== ev[i]) begin errors++; $display("FAIL timeout[%0d]: got %b want %b", i, o, ev[i]); end
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (o !== 9'b0) begin errors++; $display("FAIL error_exit: got %b want %b", o, 9'b0); end
    endtask

    task automatic test_ack_at_limit();
        logic [3:0] iv [5] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        logic [8:0] ev [5] = '{9'b100000010, 9'b100000010, 9'b100000010, 9'b100000010, 9'b010000010};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            {start, halt, m.imem_ack, m.dmem_ack} = iv[i];
            @(negedge clk);
            checks++;
            if (o !== ev[i]) begin errors++; $display("FAIL ack_limit[%0d]: got %b want %b", i, o, ev[i]); end
        end
    endtask

    task automatic test_halt();
        logic [3:0] iv [15] = '{4'b1000, 4'b0010, 4'b0000, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b1110,
                                4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        logic [8:0] ev [15] = '{9'b100000010, 9'b010000010, 9'b000000010, 9'b001000010, 9'b000010010,
                                9'b000001010, 9'b000000000, 9'b000000000, 9'b100000010, 9'b010000010,
                                9'b000000010, 9'b001000010, 9'b000010010, 9'b000001010, 9'b100000010};
        do_reset();
        {MemRead, RegWrite} = 2'b11;
        for (int i = 0; i < 15; i++) begin
            {start, halt, m.imem_ack, m.dmem_ack} = iv[i];
            @(negedge clk);
            checks++;
            if (o !== ev[i]) begin errors++; $display("FAIL halt[%0d]: got %b want %b", i, o, ev[i]); end
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [3:0] iv [6] = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        logic [8:0] ev [6] = '{9'b100000010, 9'b010000010, 9'b000000010,
                               9'b001000110, 9'b000000000, 9'b000000000};
        do_reset();
        {Uncondbranch, MemRead, RegWrite} = 3'b111;
        for (int i = 0; i < 6; i++) begin
            rst_n = i != 4;
            {start, halt, m.imem_ack, m.dmem_ack} = iv[i];
            @(negedge clk);
            checks++;
            if (o !== ev[i]) begin errors++; $display("FAIL rst_mem[%0d]: got %b want %b", i, o, ev[i]); end
        end
    endtask

    task automatic test_count();
        do_reset();
        for (int i = 0; i < 22; i++) begin
            {start, halt, m.imem_ack, m.dmem_ack} = i == 0 ? 4'b1010 : i == 17 ? 4'b0110 : 4'b0010;
            @(negedge clk);
            if (i == 12) begin
                checks++;
                if (retired_count !== 32'(CNT_ON * 3)) begin
                    errors++; $display("FAIL count3: got %0d want %0d", retired_count, CNT_ON * 3);
                end
                checks++;
                if (rc2 !== 2'(CNT_ON * 3)) begin
                    errors++; $display("FAIL count3_w2: got %0d want %0d", rc2, CNT_ON * 3);
                end
            end
        end
        checks++;
        if (retired_count !== 32'(CNT_ON * 5)) begin
            errors++; $display("FAIL count5: got %0d want %0d", retired_count, CNT_ON * 5);
        end
        checks++;
        if (rc2 !== 2'(CNT_ON)) begin errors++; $display("FAIL count_wrap: got %0d want %0d", rc2, CNT_ON); end
        checks++;
        if (o !== 9'b0) begin errors++; $display("FAIL count_idle: got %b want %b", o, 9'b0); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load();
        test_store();
        test_branch();
        test_timeout();
        test_ack_at_limit();
        test_halt();
        test_reset_mid_mem();
        test_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
